bin2gray_cnt: RTL
=================

// Module: bin2gray_cnt
// PURPOSE
//  Up/down binary counter with a registered Gray-code output. Encode-side
//  counterpart of the Gray-to-binary converter: produces the Gray sequence that
//  converter decodes. Used as a single-bit-change position/pointer source.
//  Binary and Gray views update together, so gray == bin ^ (bin >> 1) always.
// PARAMETERS
//  W        4   counter / code width in bits (W >= 2)
//  RST_VAL  0   binary value loaded on reset (W bits); gray resets to its code
// PORTS
//  clk       in   1  clock, all state updates on rising edge
//  rst       in   1  synchronous reset, active high
//  en        in   1  count enable: one step per cycle while high
//  up        in   1  direction: 1 = increment, 0 = decrement
//  load      in   1  synchronous load of load_val (overrides en)
//  load_val  in   W  binary value to load
//  bin       out  W  registered binary count
//  gray      out  W  registered Gray code of bin
//  tc        out  1  terminal count (combinational from bin and up)
//  wrap      out  1  registered 1-cycle pulse: last step wrapped around
//  chg       out  1  registered 1-cycle pulse: gray changed on last edge
// BEHAVIOUR
//  - Priority per edge: rst > load > en > hold.
//  - rst: bin<=RST_VAL, gray<=RST_VAL^(RST_VAL>>1), wrap<=0, chg<=0.
//    Reset mid-count discards the step in that cycle; no wrap/chg pulse.
//  - load: bin<=load_val, gray<=load_val^(load_val>>1), wrap<=0;
//    chg<=1 only if new gray differs from current gray. en ignored that cycle.
//  - en & up: bin<=(bin+1) mod 2^W. en & !up: bin<=(bin-1) mod 2^W.
//    gray updated in the same edge from the NEXT bin value (not a 2-stage
//    pipe): latency from en sampled high to new bin/gray visible = 1 cycle.
//  - Every en step changes exactly one gray bit, including wrap steps
//    (2^W-1 -> 0 and 0 -> 2^W-1); chg<=1 on every en step.
//  - wrap<=1 when an en step goes 2^W-1->0 (up) or 0->2^W-1 (down), else 0.
//  - tc = up ? (bin == 2^W-1) : (bin == 0); may toggle with up without a clock.
//  - Hold (no rst/load/en): bin, gray unchanged; wrap<=0, chg<=0.
//  - Direction change on any cycle is legal; takes effect on that edge's step.
//  - No X on outputs after first rst edge; outputs undefined before it.
// TESTING
//  1. rst=1 one cycle, W=4, RST_VAL=0 -> bin=0, gray=0000, wrap=0, chg=0, tc=1 (up=1? no: tc=0 up, 1 down).
//  2. up=1, en=1 for 16 cycles from 0 -> gray 0000,0001,0011,0010,0110,...,1000
//     then 0000; each step one bit differs; wrap=1 only after 15->0; chg=1 each.
//  3. up=0, en=1 from bin=0 -> bin=15, gray=1000, wrap=1; next step bin=14,
//     gray=1001, wrap=0; tc=1 while bin=0 and up=0.
//  4. load=1, en=1, load_val=1010 -> bin=1010, gray=1111, en ignored, wrap=0;
//     load of the current value again -> chg=0.
//  5. rst asserted while en=1, up=1 at bin=7 -> next cycle bin=RST_VAL, no
//     wrap/chg pulse; counting resumes the cycle after rst drops.
//  6. Random en/up/load for 1000 cycles -> gray == bin^(bin>>1) every cycle,
//     and decoding gray back to binary equals bin.

Source files
------------

// File: rtl/bin2gray_cnt_if.sv
// rtl/bin2gray_cnt_if.sv - control/status bundle for the up/down Gray-code counter
interface bin2gray_cnt_if #(
    parameter int W = 4
);
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         tc;
    logic         wrap;
    logic         chg;

    modport master (
        output en, up, load, load_val,
        input  bin, gray, tc, wrap, chg
    );

    modport slave (
        input  en, up, load, load_val,
        output bin, gray, tc, wrap, chg
    );
endinterface

// File: rtl/bin2gray_cnt.sv
// rtl/bin2gray_cnt.sv - up/down binary counter with registered Gray-code view
module bin2gray_cnt #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    bin2gray_cnt_if.slave bus
);

    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic [W-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic         wrap_q;
    logic         chg_q;

    logic [W-1:0] step_bin;
    logic [W-1:0] step_gray;
    logic         step_wrap;
    logic [W-1:0] load_gray;

    // Gray is derived from the next binary value so both views move on the same edge.
    always_comb begin
        step_bin  = bus.up ? (bin_q + W'(1)) : (bin_q - W'(1));
        step_gray = step_bin ^ (step_bin >> 1);
        step_wrap = bus.up ? (bin_q == MAX_VAL) : (bin_q == '0);
        load_gray = bus.load_val ^ (bus.load_val >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= RST_VAL;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
            chg_q  <= 1'b0;
        end else if (bus.load) begin
            bin_q  <= bus.load_val;
            gray_q <= load_gray;
            wrap_q <= 1'b0;
            chg_q  <= (load_gray != gray_q);
        end else if (bus.en) begin
            bin_q  <= step_bin;
            gray_q <= step_gray;
            wrap_q <= step_wrap;
            chg_q  <= 1'b1;
        end else begin
            wrap_q <= 1'b0;
            chg_q  <= 1'b0;
        end
    end

    // Terminal count follows the direction input combinationally.
    always_comb begin
        bus.bin  = bin_q;
        bus.gray = gray_q;
        bus.wrap = wrap_q;
        bus.chg  = chg_q;
        bus.tc   = bus.up ? (bin_q == MAX_VAL) : (bin_q == '0);
    end

endmodule
